// File: rtl/posit_to_float_es3.sv
// posit_to_float_es3: converts a posit(32,3) operand to IEEE-754 binary32.
// Pipeline: an input capture register, then decode, round and pack stages.
// Results appear three clock cycles after the edge that captured start.
//
// Handshake: start is a valid-only strobe. Every cycle with start=1 is one
// conversion. There is no ready and no backpressure. done is high for one
// cycle per conversion. result and the four flags are meaningful only while
// done=1, and they hold their previous values while done=0.
module posit_to_float_es3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  output logic [31:0] result,
  output logic        inf,
  output logic        zero,
  output logic        overflow,
  output logic        underflow,
  output logic        done
);

  // Capture register. An X on an input bit becomes 0.
  logic        start_clean;
  logic [31:0] in_clean;
  logic        v0;
  logic [31:0] in_q;

  // Decode stage.
  logic               v1, sign1, nar1, zero1;
  logic signed [9:0]  scale1;
  logic [25:0]        frac1;

  // Round stage.
  logic               v2, sign2, nar2, zero2;
  logic signed [9:0]  scale2;
  logic [22:0]        frac2;

  // X-to-0 cleanup of the raw inputs before they are captured.
  always_comb begin
    start_clean = (start === 1'b1);
    for (int i = 0; i < 32; i++) in_clean[i] = (in[i] === 1'b1);
  end

  // Capture the strobe and operand on every edge. reset discards a start seen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) v0 <= 1'b0;
    else       v0 <= start_clean;
    in_q <= in_clean;
  end

  // Decode: magnitude, regime run length, exponent and left-aligned fraction.
  logic [30:0]       mag;
  logic [5:0]        run;
  logic              going;
  logic [28:0]       body;
  logic signed [9:0] k_d;
  logic signed [9:0] scale_d;
  always_comb begin
    mag   = in_q[31] ? 31'(-in_q[30:0]) : in_q[30:0];
    run   = 6'd0;
    going = 1'b1;
    for (int i = 30; i >= 0; i--) begin
      if (going && (mag[i] == mag[30])) run = run + 6'd1;
      else                              going = 1'b0;
    end
    // The regime always takes at least two bits (mag[30] and its terminator).
    // Shift the rest left so the exponent lands in body[28:26].
    body    = mag[28:0] << (run - 6'd1);
    k_d     = mag[30] ? ($signed({4'b0, run}) - 10'sd1) : -$signed({4'b0, run});
    scale_d = (k_d <<< 3) + $signed({7'b0, body[28:26]});
  end

  // Decode stage register.
  always_ff @(posedge clk) begin
    if (reset) v1 <= 1'b0;
    else       v1 <= v0;
    sign1  <= in_q[31];
    nar1   <= (in_q == 32'h8000_0000);
    zero1  <= (in_q == 32'h0000_0000);
    scale1 <= scale_d;
    frac1  <= body[25:0];
  end

  // Round 26 to 23 fraction bits, to nearest with ties to even.
  logic        inc;
  logic [23:0] sum;
  always_comb begin
    inc = frac1[2] & ((|frac1[1:0]) | frac1[3]);
    sum = {1'b0, frac1[25:3]} + {23'b0, inc};
  end

  // Round stage register. A carry out leaves the fraction at zero and bumps the scale.
  always_ff @(posedge clk) begin
    if (reset) v2 <= 1'b0;
    else       v2 <= v1;
    sign2  <= sign1;
    nar2   <= nar1;
    zero2  <= zero1;
    frac2  <= sum[22:0];
    scale2 <= scale1 + $signed({9'b0, sum[23]});
  end

  // Pack the binary32 word, saturating large scales and flushing small ones.
  logic [31:0] res_d;
  logic [3:0]  flags_d;  // {inf, zero, overflow, underflow}
  always_comb begin
    res_d   = {sign2, 8'(scale2 + 10'sd127), frac2};
    flags_d = 4'b0000;
    if (nar2) begin
      res_d   = 32'h7FC0_0000;
      flags_d = 4'b1000;
    end else if (zero2) begin
      res_d   = 32'h0000_0000;
      flags_d = 4'b0100;
    end else if (scale2 > 10'sd127) begin
      res_d   = {sign2, 31'h7F7F_FFFF};
      flags_d = 4'b0010;
    end else if (scale2 < -10'sd126) begin
      res_d   = {sign2, 31'h0};
      flags_d = 4'b0001;
    end
  end

  // Output register. It updates only when a conversion completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      result    <= 32'h0;
      inf       <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= v2;
      if (v2) begin
        result                           <= res_d;
        {inf, zero, overflow, underflow} <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_posit_to_float_es3.sv
// tb_posit_to_float_es3: directed and streaming checks of posit_to_float_es3.
module tb_posit_to_float_es3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] in_v;
  logic [31:0] result;
  logic        inf, zero, overflow, underflow, done;

  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;

  posit_to_float_es3 dut (
    .clk(clk), .reset(reset), .start(start), .in(in_v),
    .result(result), .inf(inf), .zero(zero), .overflow(overflow),
    .underflow(underflow), .done(done)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Comparison point
  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {result, inf, zero, overflow, underflow};
  endfunction

  // Reference model: walks the posit bit by bit, then applies general RNE to 23 bits
  function automatic logic [35:0] model(input logic [31:0] p);
    logic s, r0;
    logic [31:0] v;
    int idx, run, k, e, nf, sc, sh;
    longint unsigned f, q, rem, half;
    if (p == 32'h0) return {32'h0, 4'b0100};
    if (p == 32'h8000_0000) return {32'h7FC0_0000, 4'b1000};
    s = p[31];
    v = s ? (~p + 32'd1) : p;
    idx = 30; r0 = v[30]; run = 0;
    while (idx >= 0 && v[idx] == r0) begin run++; idx--; end
    idx--;
    k = r0 ? run - 1 : -run;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((idx >= 0) ? int'(v[idx]) : 0);
      idx--;
    end
    f = 0; nf = 0;
    while (idx >= 0) begin f = f * 2 + longint'(v[idx]); nf++; idx--; end
    sc = 8 * k + e;
    if (nf <= 23) q = f << (23 - nf);
    else begin
      sh   = nf - 23;
      q    = f >> sh;
      rem  = f & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == (64'd1 << 23)) begin q = 0; sc++; end
    if (sc > 127)  return {s, 31'h7F7F_FFFF, 4'b0010};
    if (sc < -126) return {s, 31'h0, 4'b0001};
    return {s, 8'(sc + 127), q[22:0], 4'b0000};
  endfunction

  // Driver: one isolated conversion, checking latency, value and hold
  task automatic convert(input logic [31:0] p, input logic [35:0] exp, input string tag);
    @(negedge clk); in_v = p; start = 1'b1;
    @(negedge clk); start = 1'b0; in_v = $urandom();
    @(negedge clk);
    @(negedge clk); check({tag, "_early"}, {35'b0, done}, 36'd0);
    @(negedge clk); check({tag, "_done"},  {35'b0, done}, 36'd1);
    check(tag, outs(), exp);
    @(negedge clk); check({tag, "_hold"},  {done, outs()} , {1'b0, exp});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_v = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 36'h0);
    check("reset_done", {35'b0, done}, 36'd0);

    // start together with reset is discarded
    start = 1'b1; in_v = 32'h4000_0000;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("rst_start_discard", {35'b0, done}, 36'd0);
    end

    // Directed vectors, hand-computed
    convert(32'h4000_0000, {32'h3F80_0000, 4'b0000}, "one");
    convert(32'hC000_0000, {32'hBF80_0000, 4'b0000}, "neg_one");
    convert(32'h4400_0000, {32'h4000_0000, 4'b0000}, "two");
    convert(32'h4000_0004, {32'h3F80_0000, 4'b0000}, "tie_even");
    convert(32'h4000_000C, {32'h3F80_0002, 4'b0000}, "tie_odd");
    convert(32'h4000_0005, {32'h3F80_0001, 4'b0000}, "round_up");
    convert(32'h5FFF_FFFF, {32'h4380_0000, 4'b0000}, "round_carry");
    convert(32'h7FFF_FFFF, {32'h7F7F_FFFF, 4'b0010}, "maxpos");
    convert(32'h0000_0001, {32'h0000_0000, 4'b0001}, "minpos");
    convert(32'hFFFF_FFFF, {32'h8000_0000, 4'b0001}, "neg_minpos");
    convert(32'h8000_0000, {32'h7FC0_0000, 4'b1000}, "nar");
    convert(32'h0000_0000, {32'h0000_0000, 4'b0100}, "zero");
    convert(32'h7FFF_B800, {32'h7F00_0000, 4'b0000}, "scale_127");
    convert(32'h7FFF_C000, {32'h7F7F_FFFF, 4'b0010}, "scale_128");
    convert(32'h0000_5000, {32'h0080_0000, 4'b0000}, "scale_m126");
    convert(32'h0000_4800, {32'h0000_0000, 4'b0001}, "scale_m127");
    convert(32'hFFFF_B000, {32'h8080_0000, 4'b0000}, "neg_scale_m126");

    // Streaming: 100 back-to-back random conversions
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        check("stream_done", {35'b0, done}, 36'd1);
        exp_w = exp_q.pop_front();
        check("stream_data", outs(), exp_w);
      end
      if (c < 100) begin
        start = 1'b1;
        in_v  = $urandom();
        if (c % 10 == 0) in_v = {in_v[31], 12'h000, in_v[18:0]};
        exp_q.push_back(model(in_v));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk); check("stream_end", {35'b0, done}, 36'd0);

    // Reset with two conversions in flight
    @(negedge clk); start = 1'b1; in_v = 32'h4000_0000;
    @(negedge clk); in_v = 32'h4400_0000;
    @(negedge clk); start = 1'b0; reset = 1'b1;
    check("midrst_pre", {35'b0, done}, 36'd0);
    @(negedge clk); reset = 1'b0;
    check("midrst_clear", {done, outs()}, 37'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("midrst_nodone", {35'b0, done}, 36'd0);
    end
    convert(32'h4400_0000, {32'h4000_0000, 4'b0000}, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/posit_to_float_es3.md
POSIT_TO_FLOAT_ES3 -- requirements
Module: posit_to_float_es3

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  input-valid strobe; one conversion per cycle while high.
REQ-004 SHALL have port in  input  32  posit(32,3) operand, two's-complement encoded.
REQ-005 SHALL have port result  output  32  IEEE-754 binary32 result.
REQ-006 SHALL have port inf  output  1  high when the input was NaR.
REQ-007 SHALL have port zero  output  1  high when the input was posit zero.
REQ-008 SHALL have port overflow  output  1  high when the output was saturated to max finite.
REQ-009 SHALL have port underflow  output  1  high when the output was flushed to zero.
REQ-010 SHALL have port done  output  1  result/flags valid strobe.

Function
REQ-011 SHALL sample in and start every clock; X on in or start is treated as 0.
REQ-012 SHALL be a 3-stage pipeline: done high exactly 3 cycles after the edge that sampled start=1, with result/flags for that input.
REQ-013 SHALL accept back-to-back start (throughput 1 per cycle); no stall, no backpressure.
REQ-014 Stage 1 SHALL decode: sign = in[31]; magnitude = two's complement of in[30:0] when sign=1; regime run-length k (leading-1 run n gives k=n-1, leading-0 run n gives k=-n); 3 exponent bits e (missing bits = 0); up to 26 fraction bits left-aligned; scale = 8k + e (signed, 9 bits, range -240..240).
REQ-015 Stage 2 SHALL round the 26-bit fraction to 23 bits, round-to-nearest-even: guard = bit 2, sticky = OR of bits 1..0; increment on guard & (sticky | lsb).
REQ-016 Rounding carry out of the 23-bit fraction SHALL zero the fraction and increment scale by 1.
REQ-017 Stage 3 SHALL pack: biased exponent = scale + 127 (8 bits), fraction 23 bits, sign as decoded.
REQ-018 Post-rounding scale > 127 SHALL give {sign, 0x7F7FFFFF[30:0]} and overflow=1; output never encodes infinity except as below.
REQ-019 Scale < -126 SHALL give {sign, 31'b0} (flush-to-zero, no denormals) and underflow=1.
REQ-020 in = 0x80000000 (NaR) SHALL give result 0x7FC00000, inf=1, other flags 0.
REQ-021 in = 0x00000000 SHALL give result 0x00000000, zero=1, other flags 0.
REQ-022 At most one of inf, zero, overflow, underflow SHALL be high per result.
REQ-023 result and flags SHALL hold their last values while done=0; only done qualifies them.

Reset
REQ-024 reset=1 SHALL clear all pipeline valid bits, result, inf, zero, overflow, underflow, done to 0 on the next edge.
REQ-025 Conversions in flight at reset SHALL be discarded; done SHALL stay 0 until 3 cycles after the first start sampled with reset=0.
REQ-026 reset and start high in the same cycle SHALL discard that start.

Verification
REQ-027 in=0x40000000, start pulse -> 3 cycles later done=1, result=0x3F800000; in=0xC0000000 -> 0xBF800000; in=0x44000000 -> 0x40000000.
REQ-028 Rounding: in=0x40000004 -> 0x3F800000 (tie, even); in=0x4000000C -> 0x3F800002 (tie, odd rounds up); in=0x40000005 -> 0x3F800001.
REQ-029 Extremes: in=0x7FFFFFFF -> 0x7F7FFFFF, overflow=1; in=0x00000001 -> 0x00000000, underflow=1; in=0xFFFFFFFF -> 0x80000000, underflow=1.
REQ-030 Specials: in=0x80000000 -> 0x7FC00000, inf=1; in=0x00000000 -> 0x00000000, zero=1.
REQ-031 Streaming: 100 random inputs with start held high -> 100 consecutive done cycles, results in order, each bit-exact vs. software posit-to-float model.
REQ-032 Reset mid-stream: assert reset for 1 cycle with 2 conversions in flight -> no done for those; next start yields done exactly 3 cycles later.
